// File: rtl/mips32_pkg.sv
// Shared MIPS32 front-end definitions: opcode constants, instruction classes
// and the fetch-queue entry layout.
package mips32_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_I = 2'd1,
    ITYPE_J = 2'd2
  } instr_type_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

  function automatic instr_type_e instr_type(input logic [31:0] ir);
    case (ir[31:26])
      OP_SPECIAL:   return ITYPE_R;
      OP_J, OP_JAL: return ITYPE_J;
      default:      return ITYPE_I;
    endcase
  endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response, decode handoff,
// and the redirect/halt controls from the back end.
interface mips32_fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  modport master (
    output imem_req, imem_addr, if_valid, if_ir, if_npc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_ir, if_npc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready,
           redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/mips32_sync_fifo.sv
// Circular instruction queue of fetch entries with push, pop, flush and an
// occupancy count; the head is read straight from storage, never bypassed.
module mips32_sync_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of the order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observable
  // while r_count covers it, so its power-up contents never leak out.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  // Credit accounting upstream must make this unreachable.
  a_no_push_on_full: assert property (@(posedge clk) disable iff (rst)
    !(w_do_push && (r_count == DEPTH[CW-1:0])));

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch queue: credit-limited request issue, in-order
// response capture, and redirect flush with discard of stale responses.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  mips32_fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          w_grant;
  logic          w_dropping;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // Queued entries plus outstanding requests (stale ones included) consume credit.
  assign w_used        = {1'b0, w_count} + {1'b0, r_inflight};
  assign bus.imem_req  = !bus.halt && !bus.redirect_valid && (w_used < DEPTH_W);
  assign bus.imem_addr = r_fetch_pc;

  assign w_grant     = bus.imem_req && bus.imem_gnt;
  assign w_dropping  = bus.redirect_valid || (r_drop_cnt != '0);
  assign w_push      = bus.imem_rvalid && !w_dropping;
  assign w_pop       = bus.if_valid && bus.id_ready && !bus.redirect_valid;
  assign w_push_data = '{ir: bus.imem_rdata, npc: r_rsp_pc + 32'd1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      case ({w_grant, bus.imem_rvalid})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: ;
      endcase
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
        r_rsp_pc   <= bus.redirect_pc;
        // Everything still outstanding after this edge belongs to the old path.
        r_drop_cnt <= r_inflight - CW'(bus.imem_rvalid);
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd1;
        if (w_push)  r_rsp_pc   <= r_rsp_pc + 32'd1;
        if (bus.imem_rvalid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  mips32_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.if_valid = (w_count != '0);
  assign bus.if_ir    = w_head.ir;
  assign bus.if_npc   = w_head.npc;

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: directed scenarios then random
// traffic, all compared against a queue-based model of the fetch rules.
module tb_mips32_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  // Outstanding request as the model sees it: address, old-path flag, due cycle.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mips32_fetch_queue_if bus();

  mips32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lat     = 1;
  int          n_grant = 0;
  logic [31:0] salt    = 32'd0;
  logic [31:0] m_fetch_pc;
  ent_t        q[$];
  req_t        os[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check request outputs, take the edge, advance the model,
  // check decode outputs, and let the memory present its next response.
  task automatic cycle();
    bit          acc, rv, rd, pop;
    logic [31:0] addr, rpc, rdat;
    req_t        o;
    #1;
    rd   = bus.redirect_valid;
    rpc  = bus.redirect_pc;
    rv   = bus.imem_rvalid;
    rdat = bus.imem_rdata;
    acc  = bus.imem_req && bus.imem_gnt;
    addr = bus.imem_addr;
    pop  = (q.size() != 0) && bus.id_ready;
    check("imem_req", 32'(bus.imem_req),
          32'(!bus.halt && !rd && ((q.size() + os.size()) < DEPTH)));
    check("imem_addr", addr, m_fetch_pc);
    @(posedge clk);
    #1;
    if (pop && !rd) void'(q.pop_front());
    if (rv) begin
      o = os.pop_front();
      if (!o.stale && !rd) q.push_back('{rdat, o.addr + 32'd1});
    end
    if (rd) begin
      q.delete();
      foreach (os[i]) os[i].stale = 1'b1;
      m_fetch_pc = rpc;
    end
    if (acc) begin
      os.push_back('{addr, 1'b0, cyc + lat});
      m_fetch_pc++;
      n_grant++;
    end
    cyc++;
    check("if_valid", 32'(bus.if_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("if_ir", bus.if_ir, q[0].ir);
      check("if_npc", bus.if_npc, q[0].npc);
    end
    if (os.size() != 0 && os[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(os[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
    end
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    logic h;
    h = bus.halt;
    #2;
    rst = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_ir", bus.if_ir, 32'd0);
    check("rst_if_npc", bus.if_npc, 32'd0);
    check("rst_imem_addr", bus.imem_addr, RESET_PC);
    bus.halt = 1'b1;
    #1;
    check("rst_req_halt", 32'(bus.imem_req), 32'd0);
    bus.halt = 1'b0;
    #1;
    check("rst_req_run", 32'(bus.imem_req), 32'd1);
    bus.halt = h;
    q.delete();
    os.delete();
    m_fetch_pc = RESET_PC;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!bus.if_valid && k < budget) begin
      cycle();
      k++;
    end
    check(tag, 32'(bus.if_valid), 32'd1);
  endtask

  initial begin
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'd0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.halt           = 1'b0;
    async_reset();

    // Streaming at 1-cycle latency: two-cycle fill, then npc 1, 2, 3 ...
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    lat = 1;
    cycle();
    check("fill_not_yet", 32'(bus.if_valid), 32'd0);
    cycle();
    check("fill_valid", 32'(bus.if_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("stream_npc", bus.if_npc, 32'(i + 1));
      cycle();
    end

    // Decode stalled: exactly DEPTH grants, then requests stop.
    async_reset();
    bus.id_ready = 1'b0;
    n_grant = 0;
    repeat (10) cycle();
    check("stall_grants", 32'(n_grant), 32'(DEPTH));
    check("stall_req", 32'(bus.imem_req), 32'd0);
    bus.id_ready = 1'b1;
    repeat (6) cycle();

    // Latency 3, two requests in flight, redirect to 0x40: both responses dropped.
    async_reset();
    lat = 3;
    cycle();
    cycle();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    cycle();
    bus.redirect_valid = 1'b0;
    bus.imem_gnt       = 1'b1;
    wait_valid("redir_timeout", 16);
    check("redir_ir", bus.if_ir, 32'h40);
    check("redir_npc", bus.if_npc, 32'h41);

    // Redirect coinciding with rvalid and a pop.
    lat = 2;
    repeat (6) cycle();
    check("pre_redir_valid", 32'(bus.if_valid), 32'd1);
    check("pre_redir_rvalid", 32'(bus.imem_rvalid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    cycle();
    bus.redirect_valid = 1'b0;
    check("flush_empty", 32'(bus.if_valid), 32'd0);
    wait_valid("flush_timeout", 16);
    check("flush_npc", bus.if_npc, 32'h81);

    // Halt: in-flight work drains, then nothing more.
    repeat (5) cycle();
    bus.halt = 1'b1;
    repeat (8) cycle();
    check("halt_empty", 32'(bus.if_valid), 32'd0);
    check("halt_req", 32'(bus.imem_req), 32'd0);
    bus.halt = 1'b0;

    // Asynchronous reset mid-stream: fetch restarts at RESET_PC.
    lat = 1;
    repeat (4) cycle();
    async_reset();
    cycle();
    cycle();
    check("restart_npc", bus.if_npc, RESET_PC + 32'd1);

    // Random traffic against the model, including address wrap and a reset.
    salt = $urandom;
    for (int i = 0; i < 800; i++) begin
      bus.imem_gnt       = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.halt           = ($urandom_range(0, 15) == 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
      lat                = $urandom_range(1, 4);
      if (i == 400) async_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of instruction queue entries (power of two, >= 2).
REQ-002 Parameter RESET_PC, default 32'd0, SHALL set the word address fetched first after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_req  out  1  fetch request; imem_addr  out  32  word address of the request.
REQ-006 imem_gnt  in  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  in  1 / imem_rdata  in  32  in-order read response, at least 1 cycle after grant.
REQ-008 if_valid  out  1 / if_ir  out  32 / if_npc  out  32  head instruction and its address + 1, to decode.
REQ-009 id_ready  in  1  decode consumes the head when if_valid && id_ready.
REQ-010 redirect_valid  in  1 / redirect_pc  in  32  taken branch from EX/MEM; new fetch address.
REQ-011 halt  in  1  stops new requests while high.

Function
REQ-012 imem_req SHALL be combinational: !halt && !redirect_valid && (count + inflight) < DEPTH.
REQ-013 imem_addr SHALL equal fetch_pc; fetch_pc SHALL increment by 1 (mod 2^32) on each imem_req && imem_gnt.
REQ-014 imem_req SHALL be allowed to drop without grant; memory SHALL NOT see an ungranted request as accepted.
REQ-015 inflight SHALL count granted, unreturned requests: +1 on grant, -1 on imem_rvalid, both in one cycle leaves it unchanged.
REQ-016 Each kept response SHALL push {imem_rdata, rsp_pc + 1} at the tail; rsp_pc SHALL then increment by 1.
REQ-017 The credit rule in REQ-012 SHALL guarantee that a push never meets a full queue; push-on-full SHALL be an assertion failure.
REQ-018 if_valid SHALL equal (count != 0); if_ir/if_npc SHALL be the head entry, registered, without bypass from imem_rdata.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; on empty, a pushed entry SHALL become visible the next cycle.
REQ-020 Latency: request granted in cycle t with rvalid at t+1 SHALL give if_valid at t+2.
REQ-021 redirect_valid SHALL, in the same edge: clear the queue (count=0), set fetch_pc and rsp_pc to redirect_pc, and set drop_cnt to inflight minus any rvalid this cycle.
REQ-022 While drop_cnt != 0, each imem_rvalid SHALL be discarded and decrement drop_cnt, without pushing or advancing rsp_pc.
REQ-023 A pop coinciding with redirect_valid SHALL be ignored; an rvalid coinciding with redirect_valid SHALL be dropped.
REQ-024 Requests SHALL remain blocked while drop_cnt != 0 only if (count + inflight) >= DEPTH; drops SHALL occupy credit until returned.
REQ-025 halt SHALL block new requests only; in-flight responses SHALL still be pushed and the queue SHALL keep draining to decode.
REQ-026 redirect_valid while halt is high SHALL update fetch_pc and flush but issue no request.

Reset
REQ-027 rst SHALL set fetch_pc = rsp_pc = RESET_PC, count = inflight = drop_cnt = 0, and head/tail pointers to 0.
REQ-028 During reset and the first cycle after it: imem_req = 0 only while halt is high; if_valid = 0, if_ir = 0, if_npc = 0.
REQ-029 Reset mid-transaction SHALL abandon in-flight requests; the memory is reset by the same rst.

Structure
REQ-030 Package mips32_pkg SHALL hold the opcode constants, the instruction-type encodings and the fetch entry struct {ir, npc}.
REQ-031 Queue storage SHALL be a sub-module mips32_sync_fifo (DEPTH, 64-bit entry, push/pop/flush, count).
REQ-032 Credit, drop and PC logic SHALL stay in mips32_fetch_queue.

Verification
REQ-033 Reset, memory returns word k at address k with 1-cycle latency, id_ready=1 -> if_npc sequence 1, 2, 3, ..., one per cycle after a 2-cycle fill.
REQ-034 id_ready=0 for 10 cycles -> exactly DEPTH=4 requests granted, count=4, imem_req=0, with no overflow assertion.
REQ-035 Memory latency 3 with 2 requests in flight, redirect_pc=32'h40 -> 2 responses dropped; first if_ir=Mem[0x40], if_npc=0x41.
REQ-036 Redirect in the same cycle as rvalid and pop -> queue empty next cycle, response dropped, drop_cnt=inflight-1.
REQ-037 halt=1 with 2 requests in flight -> 2 entries delivered, then if_valid=0 and imem_req=0 for as long as halt is high.
REQ-038 rst pulsed asynchronously mid-stream -> outputs are reset values before the next edge; fetch restarts at RESET_PC.
